// File: rtl/axi4_lite_pkg.sv
// Shared constants and state types for the AXI4-Lite master/slave pair.
// Imported by the register slave and the top-level master.
`default_nettype none

package axi4_lite_pkg;

    localparam int AXI_ADDR_W   = 4;
    localparam int AXI_DATA_W   = 32;
    localparam int AXI_NUM_REGS = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        M_IDLE,
        M_WR,
        M_WRESP,
        M_RADDR,
        M_RDATA
    } mst_state_t;

    typedef enum logic {
        SW_IDLE,
        SW_RESP
    } slv_wr_state_t;

    typedef enum logic {
        SR_IDLE,
        SR_DATA
    } slv_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave with a small word-indexed register file.
// AW and W are accepted independently; the write lands once both are in.
`default_nettype none

module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W   = AXI_ADDR_W,
    parameter int DATA_W   = AXI_DATA_W,
    parameter int NUM_REGS = AXI_NUM_REGS
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic [1:0]        rresp
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    slv_wr_state_t     wst_q, wst_d;
    slv_rd_state_t     rst_q, rst_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;

    logic              awready_d, wready_d, bvalid_d;
    logic [1:0]        bresp_d;
    logic              arready_d, rvalid_d;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;

    logic              we;
    logic [IDX_W-1:0]  we_idx;
    logic [DATA_W-1:0] we_data;

    logic aw_hs, w_hs, ar_hs;
    logic unused_addr_lsb;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // Byte offset within a word carries no meaning for full-word registers.
    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

    // Write side: collect AW and W, commit the word, then hold B until taken.
    always_comb begin
        wst_d     = wst_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        widx_d    = widx_q;
        wbuf_d    = wbuf_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid;
        bresp_d   = bresp;
        we        = 1'b0;
        we_idx    = widx_q;
        we_data   = wbuf_q;
        unique case (wst_q)
            SW_IDLE: begin
                awready_d = awvalid & ~awready & ~aw_got_q;
                wready_d  = wvalid & ~wready & ~w_got_q;
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    widx_d   = awaddr[IDX_W+1:2];
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wbuf_d  = wdata;
                end
                if (aw_got_d && w_got_d) begin
                    we       = 1'b1;
                    we_idx   = widx_d;
                    we_data  = wbuf_d;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                    wst_d    = SW_RESP;
                end
            end
            SW_RESP: begin
                if (bvalid && bready) begin
                    bvalid_d = 1'b0;
                    wst_d    = SW_IDLE;
                end
            end
            default: wst_d = SW_IDLE;
        endcase
    end

    // Read side: one-cycle ARREADY, then hold R until the master takes it.
    always_comb begin
        rst_d     = rst_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
        rresp_d   = rresp;
        unique case (rst_q)
            SR_IDLE: begin
                arready_d = arvalid & ~arready;
                if (ar_hs) begin
                    rvalid_d = 1'b1;
                    rdata_d  = regs[araddr[IDX_W+1:2]];
                    rresp_d  = RESP_OKAY;
                    rst_d    = SR_DATA;
                end
            end
            SR_DATA: begin
                if (rvalid && rready) begin
                    rvalid_d = 1'b0;
                    rst_d    = SR_IDLE;
                end
            end
            default: rst_d = SR_IDLE;
        endcase
    end

    // State, channel outputs and register file update.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            wst_q    <= SW_IDLE;
            rst_q    <= SR_IDLE;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            widx_q   <= '0;
            wbuf_q   <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wst_q    <= wst_d;
            rst_q    <= rst_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            widx_q   <= widx_d;
            wbuf_q   <= wbuf_d;
            awready  <= awready_d;
            wready   <= wready_d;
            bvalid   <= bvalid_d;
            bresp    <= bresp_d;
            arready  <= arready_d;
            rvalid   <= rvalid_d;
            rdata    <= rdata_d;
            rresp    <= rresp_d;
            if (we) begin
                regs[we_idx] <= we_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_master_slave.sv
// One-shot user request to AXI4-Lite master, wired to a register slave.
// Every internal channel signal is also exported for monitoring.
`default_nettype none

module axi4_lite_master_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W   = AXI_ADDR_W,
    parameter int DATA_W   = AXI_DATA_W,
    parameter int NUM_REGS = AXI_NUM_REGS
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
    input  logic              transfer,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    output logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              RREADY,
    output logic [1:0]        RRESP
);

    mst_state_t        st_q, st_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdata_d;
    logic              awvalid_d, wvalid_d, bready_d;
    logic              arvalid_d, rready_d, ready_d;

    // One latched address serves both AW and AR; only one is ever valid.
    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign WDATA  = wdat_q;

    // Master next-state: VALIDs drop only on their own handshake.
    always_comb begin
        st_d      = st_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rdata_d   = rdata;
        awvalid_d = AWVALID;
        wvalid_d  = WVALID;
        bready_d  = BREADY;
        arvalid_d = ARVALID;
        rready_d  = RREADY;
        ready_d   = 1'b0;
        unique case (st_q)
            M_IDLE: begin
                if (transfer) begin
                    addr_d = addr;
                    if (write) begin
                        wdat_d    = wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        st_d      = M_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        st_d      = M_RADDR;
                    end
                end
            end
            M_WR: begin
                if (AWVALID && AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (WVALID && WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    st_d     = M_WRESP;
                end
            end
            M_WRESP: begin
                if (BVALID && BREADY) begin
                    bready_d = 1'b0;
                    ready_d  = 1'b1;
                    st_d     = M_IDLE;
                end
            end
            M_RADDR: begin
                if (ARVALID && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    st_d      = M_RDATA;
                end
            end
            M_RDATA: begin
                if (RVALID && RREADY) begin
                    rready_d = 1'b0;
                    rdata_d  = RDATA;
                    ready_d  = 1'b1;
                    st_d     = M_IDLE;
                end
            end
            default: st_d = M_IDLE;
        endcase
    end

    // Master state and registered channel outputs.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            st_q    <= M_IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdata   <= '0;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            ready   <= 1'b0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdata   <= rdata_d;
            AWVALID <= awvalid_d;
            WVALID  <= wvalid_d;
            BREADY  <= bready_d;
            ARVALID <= arvalid_d;
            RREADY  <= rready_d;
            ready   <= ready_d;
        end
    end

    axi4_lite_reg_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_slave (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .awaddr  (AWADDR),
        .awvalid (AWVALID),
        .awready (AWREADY),
        .wdata   (WDATA),
        .wvalid  (WVALID),
        .wready  (WREADY),
        .bresp   (BRESP),
        .bvalid  (BVALID),
        .bready  (BREADY),
        .araddr  (ARADDR),
        .arvalid (ARVALID),
        .arready (ARREADY),
        .rdata   (RDATA),
        .rvalid  (RVALID),
        .rready  (RREADY),
        .rresp   (RRESP)
    );

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_master_slave.sv
// Scoreboard bench for axi4_lite_master_slave.
// Stimulus pushes expected completions; a negedge monitor checks them.
`timescale 1ns/1ps

module tb_axi4_lite_master_slave;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic        transfer;
    logic        ready;
    logic [31:0] rdata;
    logic [3:0]  AWADDR;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic        WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic        RVALID, RREADY;
    logic [1:0]  RRESP;

    axi4_lite_master_slave dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .addr     (addr),
        .write    (write),
        .wdata    (wdata),
        .transfer (transfer),
        .ready    (ready),
        .rdata    (rdata),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RRESP    (RRESP)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   aw_pend  = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: completions, response codes and AW stability.
    always @(negedge ACLK) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got ready=1 at cyc %0d expected none",
                         cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_latency"}, cyc, e.cyc);
                if (e.rd) chk({e.name, "_rdata"}, rdata, e.data);
            end
        end
        if (BVALID === 1'b1 && BREADY === 1'b1)
            chk("bresp", {30'd0, BRESP}, 32'd0);
        if (RVALID === 1'b1 && RREADY === 1'b1)
            chk("rresp", {30'd0, RRESP}, 32'd0);
        if (aw_pend)
            chk("awvalid_held", {31'd0, AWVALID}, 32'd1);
        aw_pend = (AWVALID === 1'b1) && (AWREADY !== 1'b1) &&
                  (ARESETn === 1'b0);
    end

    task automatic issue(input bit rd, input logic [3:0] a,
                         input logic [31:0] d, input logic [31:0] exp,
                         input string nm);
        exp_t e;
        addr     = a;
        write    = ~rd;
        wdata    = d;
        transfer = 1'b1;
        e.rd   = rd;
        e.data = exp;
        e.cyc  = cyc + 4;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge ACLK); #1;
        transfer = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk({nm, "_done"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input string nm);
        issue(1'b0, a, d, 32'd0, nm);
        wait_idle(nm);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                      input string nm);
        issue(1'b1, a, 32'd0, exp, nm);
        wait_idle(nm);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_valids"},
            {22'd0, AWVALID, WVALID, BVALID, ARVALID, RVALID,
             AWREADY, WREADY, ARREADY, BREADY, RREADY},
            32'd0);
        chk({nm, "_ready"}, {31'd0, ready}, 32'd0);
        chk({nm, "_rdata"}, rdata, 32'd0);
        chk({nm, "_addr"}, {24'd0, AWADDR, ARADDR}, 32'd0);
    endtask

    initial begin
        int n;
        ARESETn  = 1'b1;
        transfer = 1'b0;
        addr     = '0;
        write    = 1'b0;
        wdata    = '0;
        repeat (2) @(posedge ACLK);
        #1;
        chk_idle("reset");
        chk("reset_wdata", WDATA, 32'd0);
        ARESETn = 1'b0;
        @(posedge ACLK); #1;

        rd(4'h0, 32'd0, "rd_init");

        wr(4'h0, 32'd1, "wr0");
        wr(4'h4, 32'd2, "wr1");
        wr(4'h8, 32'd3, "wr2");
        wr(4'hC, 32'd4, "wr3");
        rd(4'h0, 32'd1, "rd0");
        rd(4'h4, 32'd2, "rd1");
        rd(4'h8, 32'd3, "rd2");
        rd(4'hC, 32'd4, "rd3");

        rd(4'h5, 32'd2, "rd_lowbits");
        wr(4'hE, 32'hDEADBEEF, "wr_e");
        rd(4'hC, 32'hDEADBEEF, "rd_dead");

        issue(1'b0, 4'h0, 32'h11, 32'd0, "wr_busy");
        addr     = 4'h4;
        write    = 1'b1;
        wdata    = 32'd9;
        transfer = 1'b1;
        @(posedge ACLK); #1;
        transfer = 1'b0;
        wait_idle("wr_busy");
        repeat (6) @(posedge ACLK);
        #1;
        rd(4'h4, 32'd2, "rd_ign1");
        rd(4'h0, 32'h11, "rd_busy0");

        issue(1'b0, 4'h8, 32'd7, 32'd0, "wr_abort");
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        chk("abort_in_wresp", {30'd0, BVALID, BREADY}, 32'd3);
        exp_q.delete();
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        chk_idle("abort_rst");
        ARESETn = 1'b0;
        repeat (4) @(posedge ACLK);
        #1;
        rd(4'h8, 32'd0, "rd_after_abort");
        rd(4'hC, 32'd0, "rd3_after_abort");

        issue(1'b0, 4'h0, 32'hA5, 32'd0, "b2b_wr");
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("b2b_ready_seen", {31'd0, ready}, 32'd1);
        issue(1'b1, 4'h0, 32'd0, 32'hA5, "b2b_rd");
        wait_idle("b2b");

        repeat (3) @(posedge ACLK);
        #1;
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
